// File: rtl/dense_layer_if.sv
// Bus bundle for dense_layer: control, RAM read ports and output RAM write port.
// No latency of its own; the activation/weight/bias RAMs answer one cycle after the address.
// No backpressure: the RAMs are fixed-latency and the output RAM always accepts y_we.
interface dense_layer_if;
    logic        start;
    logic [15:0] in_size;
    logic [15:0] out_size;
    logic [15:0] x_addr;
    logic [31:0] x_data;
    logic [15:0] w_addr;
    logic [31:0] w_data;
`ifdef DENSE_BIAS_EN
    logic [15:0] b_addr;
    logic [31:0] b_data;
`endif
    logic        y_we;
    logic [15:0] y_addr;
    logic [31:0] y_data;
    logic        busy;
    logic        done;

`ifdef DENSE_BIAS_EN
    modport slave (
        input  start, in_size, out_size, x_data, w_data, b_data,
        output x_addr, w_addr, b_addr, y_we, y_addr, y_data, busy, done
    );
    modport master (
        output start, in_size, out_size, x_data, w_data, b_data,
        input  x_addr, w_addr, b_addr, y_we, y_addr, y_data, busy, done
    );
`else
    modport slave (
        input  start, in_size, out_size, x_data, w_data,
        output x_addr, w_addr, y_we, y_addr, y_data, busy, done
    );
    modport master (
        output start, in_size, out_size, x_data, w_data,
        input  x_addr, w_addr, y_we, y_addr, y_data, busy, done
    );
`endif
endinterface

// File: rtl/dense_layer.sv
// Fully-connected layer y = sat32((W*x + b<<F) >>> F); optional bias via DENSE_BIAS_EN.
// Latency: done pulses M*(N+2+B)+1 cycles after the start edge (B=1 with bias).
// No backpressure: one MAC per cycle against fixed 1-cycle-latency RAMs; start ignored while busy.
module dense_layer #(
    parameter int FRAC_BITS = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    dense_layer_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
`ifdef DENSE_BIAS_EN
    localparam logic [2:0] S_BIAS  = 3'd2;
`endif
    localparam logic [2:0] S_MAC   = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;

    logic [2:0]         state, nxt;
    logic [15:0]        n_q, m_q, i_q, j_q, row_q;
    logic [15:0]        x_addr_q, w_addr_q;
`ifdef DENSE_BIAS_EN
    logic [15:0]        b_addr_q;
    logic signed [63:0] bias_ext;
`endif
    logic signed [63:0] acc, acc_nxt, prod, shifted;
    logic [31:0]        y_sat, y_data_q;
    logic [15:0]        y_addr_q;

    // Full-width signed product of the current activation/weight pair.
    assign prod = $signed({{32{bus.x_data[31]}}, bus.x_data}) *
                  $signed({{32{bus.w_data[31]}}, bus.w_data});
`ifdef DENSE_BIAS_EN
    assign bias_ext = $signed({{32{bus.b_data[31]}}, bus.b_data});
`endif

    // Next-state and next-accumulator decode.
    always_comb begin
        nxt     = state;
        acc_nxt = acc;
        case (state)
            S_IDLE: begin
                if (bus.start) nxt = (bus.out_size == 16'd0) ? S_FIN : S_LOAD;
            end
            S_LOAD: begin
                acc_nxt = '0;
`ifdef DENSE_BIAS_EN
                nxt = S_BIAS;
`else
                nxt = (n_q == 16'd0) ? S_WRITE : S_MAC;
`endif
            end
`ifdef DENSE_BIAS_EN
            S_BIAS: begin
                // Bias is pre-scaled so the final shift leaves it unchanged.
                acc_nxt = bias_ext <<< FRAC_BITS;
                nxt     = (n_q == 16'd0) ? S_WRITE : S_MAC;
            end
`endif
            S_MAC: begin
                acc_nxt = acc + prod;
                if (j_q == n_q - 16'd1) nxt = S_WRITE;
            end
            S_WRITE: nxt = (i_q == m_q - 16'd1) ? S_FIN : S_LOAD;
            S_FIN:   nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // Floor-shift the finished sum and clamp it to the signed 32-bit range.
    always_comb begin
        shifted = acc_nxt >>> FRAC_BITS;
        if ((&shifted[63:31]) || !(|shifted[63:31])) y_sat = shifted[31:0];
        else y_sat = shifted[63] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end

    // Sequencer, accumulator, address generators and registered result port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            acc      <= '0;
            n_q      <= '0;
            m_q      <= '0;
            i_q      <= '0;
            j_q      <= '0;
            row_q    <= '0;
            x_addr_q <= '0;
            w_addr_q <= '0;
`ifdef DENSE_BIAS_EN
            b_addr_q <= '0;
`endif
            y_data_q <= '0;
            y_addr_q <= '0;
        end else begin
            state <= nxt;
            acc   <= acc_nxt;
            j_q   <= (state == S_MAC) ? j_q + 16'd1 : 16'd0;
            if (state == S_IDLE && bus.start) begin
                n_q   <= bus.in_size;
                m_q   <= bus.out_size;
                i_q   <= '0;
                row_q <= '0;
            end
            if (state == S_WRITE) begin
                i_q   <= i_q + 16'd1;
                row_q <= row_q + n_q;
            end
            // Point the RAMs at the head of the next neuron's row.
            if (nxt == S_LOAD) begin
                x_addr_q <= '0;
                w_addr_q <= (state == S_WRITE) ? row_q + n_q : 16'd0;
`ifdef DENSE_BIAS_EN
                b_addr_q <= (state == S_WRITE) ? i_q + 16'd1 : 16'd0;
`endif
            end
            // Addresses run one ahead of the data they fetch, so advance on entry to MAC too.
            if (nxt == S_MAC) begin
                x_addr_q <= x_addr_q + 16'd1;
                w_addr_q <= w_addr_q + 16'd1;
            end
            if (nxt == S_WRITE) begin
                y_data_q <= y_sat;
                y_addr_q <= i_q;
            end
        end
    end

    assign bus.x_addr = x_addr_q;
    assign bus.w_addr = w_addr_q;
`ifdef DENSE_BIAS_EN
    assign bus.b_addr = b_addr_q;
`endif
    assign bus.y_we   = (state == S_WRITE);
    assign bus.y_addr = y_addr_q;
    assign bus.y_data = y_data_q;
    assign bus.busy   = (state != S_IDLE) && (state != S_FIN);
    assign bus.done   = (state == S_FIN);
endmodule

// File: tb/tb_dense_layer.sv
// Bench for dense_layer: two instances (FRAC_BITS 0 and 4) share the same RAM contents.
// Directed vectors with hand-computed results, plus reset-abort and start-while-busy sequences.
// RAM models answer one cycle after the address, like synchronous-read SRAM.
module tb_dense_layer;
`ifdef DENSE_BIAS_EN
    localparam int B = 1;
`else
    localparam int B = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dense_layer_if dif0 ();
    dense_layer_if dif4 ();

    dense_layer #(.FRAC_BITS(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(dif0.slave));
    dense_layer #(.FRAC_BITS(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(dif4.slave));

    logic [31:0] xmem [16];
    logic [31:0] wmem [16];
    logic [31:0] bmem [16];

    always @(posedge clk) begin
        dif0.x_data <= xmem[dif0.x_addr[3:0]];
        dif0.w_data <= wmem[dif0.w_addr[3:0]];
        dif4.x_data <= xmem[dif4.x_addr[3:0]];
        dif4.w_data <= wmem[dif4.w_addr[3:0]];
`ifdef DENSE_BIAS_EN
        dif0.b_data <= bmem[dif0.b_addr[3:0]];
        dif4.b_data <= bmem[dif4.b_addr[3:0]];
`endif
    end

    // Output RAM monitors: log every write and count done pulses.
    int          wcnt0 = 0, wcnt4 = 0, dcnt0 = 0, dcnt4 = 0;
    logic [15:0] yal0 [64];
    logic [31:0] ydl0 [64];
    logic [15:0] yal4 [64];
    logic [31:0] ydl4 [64];
    always @(negedge clk) begin
        if (dif0.y_we) begin
            yal0[wcnt0 % 64] = dif0.y_addr;
            ydl0[wcnt0 % 64] = dif0.y_data;
            wcnt0++;
        end
        if (dif4.y_we) begin
            yal4[wcnt4 % 64] = dif4.y_addr;
            ydl4[wcnt4 % 64] = dif4.y_data;
            wcnt4++;
        end
        if (dif0.done) dcnt0++;
        if (dif4.done) dcnt4++;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          n;
        int          m;
        logic [31:0] w [9];
        logic [31:0] x [3];
        logic [31:0] b [3];
        logic [31:0] y0 [3];
        logic [31:0] y4 [3];
    } vec_t;

    vec_t tbl [7];

    task automatic set_start(input logic v);
        dif0.start = v;
        dif4.start = v;
    endtask

    task automatic load_vec(input vec_t v);
        for (int k = 0; k < 16; k++) begin
            wmem[k] = (k < 9) ? v.w[k] : 32'd0;
            xmem[k] = (k < 3) ? v.x[k] : 32'd0;
            bmem[k] = (k < 3) ? v.b[k] : 32'd0;
        end
        dif0.in_size  = v.n[15:0];
        dif0.out_size = v.m[15:0];
        dif4.in_size  = v.n[15:0];
        dif4.out_size = v.m[15:0];
    endtask

    // Pulse start, then watch for done; optionally re-pulse start at cycle restart_at.
    task automatic run_pass(input int restart_at, output int d0, output int d4, output logic busy1);
        @(negedge clk);
        set_start(1'b1);
        @(posedge clk);
        d0 = -1;
        d4 = -1;
        busy1 = 1'b0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            set_start(cyc == restart_at);
            if (cyc == 1) busy1 = dif0.busy & dif4.busy;
            if (dif0.done && d0 < 0) d0 = cyc;
            if (dif4.done && d4 < 0) d4 = cyc;
            if (d0 >= 0 && d4 >= 0) break;
            @(posedge clk);
        end
        set_start(1'b0);
    endtask

    task automatic check_pass(input int vi, input vec_t v, input int restart_at);
        int   b0, b4, d0, d4;
        logic busy1;
        b0 = wcnt0;
        b4 = wcnt4;
        run_pass(restart_at, d0, d4, busy1);
        chk($sformatf("v%0d_done_cyc_f0", vi), d0, v.m * (v.n + 2 + B) + 1);
        chk($sformatf("v%0d_done_cyc_f4", vi), d4, v.m * (v.n + 2 + B) + 1);
        chk($sformatf("v%0d_busy_c1", vi), busy1, (v.m > 0));
        @(negedge clk);
        chk($sformatf("v%0d_done_single", vi), dif0.done | dif4.done, 0);
        chk($sformatf("v%0d_wr_cnt_f0", vi), wcnt0 - b0, v.m);
        chk($sformatf("v%0d_wr_cnt_f4", vi), wcnt4 - b4, v.m);
        for (int k = 0; k < v.m; k++) begin
            chk($sformatf("v%0d_yaddr%0d_f0", vi, k), yal0[(b0 + k) % 64], k);
            chk($sformatf("v%0d_y%0d_f0", vi, k), ydl0[(b0 + k) % 64], v.y0[k]);
            chk($sformatf("v%0d_yaddr%0d_f4", vi, k), yal4[(b4 + k) % 64], k);
            chk($sformatf("v%0d_y%0d_f4", vi, k), ydl4[(b4 + k) % 64], v.y4[k]);
        end
    endtask

    initial begin
        int b0, d0c;

        // 2x2 basic: sums 17, 39
        tbl[0].n = 2; tbl[0].m = 2;
        tbl[0].w = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        tbl[0].x = '{32'd5, 32'd6, 32'd0};
        tbl[0].b = '{-32'sd20, 32'd1, 32'd0};
        // positive saturation
        tbl[1].n = 2; tbl[1].m = 1;
        tbl[1].w = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        tbl[1].x = '{32'd2, 32'd2, 32'd0};
        tbl[1].b = '{32'd0, 32'd0, 32'd0};
        tbl[1].y0 = '{32'h7FFF_FFFF, 32'd0, 32'd0};
        tbl[1].y4 = '{32'h1FFF_FFFF, 32'd0, 32'd0};
        // negative saturation
        tbl[2] = tbl[1];
        tbl[2].x = '{-32'sd2, -32'sd2, 32'd0};
        tbl[2].y0 = '{32'h8000_0000, 32'd0, 32'd0};
        tbl[2].y4 = '{32'hE000_0000, 32'd0, 32'd0};
        // M=0: immediate done, no writes
        tbl[3] = tbl[0];
        tbl[3].m = 0;
        // N=0, M=3
        tbl[4].n = 0; tbl[4].m = 3;
        tbl[4].w = '{32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9};
        tbl[4].x = '{32'd9, 32'd9, 32'd9};
        tbl[4].b = '{32'd7, -32'sd1, 32'd100};
        // floor (not truncate) on negative: sum -17
        tbl[5].n = 2; tbl[5].m = 1;
        tbl[5].w = '{-32'sd3, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        tbl[5].x = '{32'd5, -32'sd2, 32'd0};
        tbl[5].b = '{32'd2, 32'd0, 32'd0};
        // 3x3 with row stepping: sums 10, -20, 20
        tbl[6].n = 3; tbl[6].m = 3;
        tbl[6].w = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd1, 32'd1, 32'd1};
        tbl[6].x = '{32'd10, -32'sd20, 32'd30};
        tbl[6].b = '{32'd1, 32'd2, 32'd3};
`ifdef DENSE_BIAS_EN
        tbl[0].y0 = '{-32'sd3, 32'd40, 32'd0};
        tbl[0].y4 = '{-32'sd19, 32'd3, 32'd0};
        tbl[4].y0 = '{32'd7, -32'sd1, 32'd100};
        tbl[4].y4 = '{32'd7, -32'sd1, 32'd100};
        tbl[5].y0 = '{-32'sd15, 32'd0, 32'd0};
        tbl[5].y4 = '{32'd0, 32'd0, 32'd0};
        tbl[6].y0 = '{32'd11, -32'sd18, 32'd23};
        tbl[6].y4 = '{32'd1, 32'd0, 32'd4};
`else
        tbl[0].y0 = '{32'd17, 32'd39, 32'd0};
        tbl[0].y4 = '{32'd1, 32'd2, 32'd0};
        tbl[4].y0 = '{32'd0, 32'd0, 32'd0};
        tbl[4].y4 = '{32'd0, 32'd0, 32'd0};
        tbl[5].y0 = '{-32'sd17, 32'd0, 32'd0};
        tbl[5].y4 = '{-32'sd2, 32'd0, 32'd0};
        tbl[6].y0 = '{32'd10, -32'sd20, 32'd20};
        tbl[6].y4 = '{32'd0, -32'sd2, 32'd1};
`endif
        tbl[3].y0 = tbl[0].y0;
        tbl[3].y4 = tbl[0].y4;

        set_start(1'b0);
        load_vec(tbl[0]);

        // Reset state
        #12;
        chk("rst_busy", dif0.busy | dif4.busy, 0);
        chk("rst_done", dif0.done | dif4.done, 0);
        chk("rst_y_we", dif0.y_we | dif4.y_we, 0);
        chk("rst_addrs", {dif0.x_addr, dif0.w_addr, dif0.y_addr}, 0);
        chk("rst_y_data", dif0.y_data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int vi = 0; vi < 7; vi++) begin
            load_vec(tbl[vi]);
            check_pass(vi, tbl[vi], 0);
        end

        // Start pulse while busy is ignored
        load_vec(tbl[0]);
        check_pass(10, tbl[0], 3);

        // Reset in the middle of MAC aborts the pass
        load_vec(tbl[0]);
        b0 = wcnt0;
        d0c = dcnt0;
        @(negedge clk);
        set_start(1'b1);
        @(posedge clk);
        #1 set_start(1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", dif0.busy | dif4.busy, 0);
        chk("midrst_done", dif0.done | dif4.done, 0);
        chk("midrst_y_we", dif0.y_we | dif4.y_we, 0);
        chk("midrst_addr", {dif0.x_addr, dif0.w_addr, dif4.x_addr}, 0);
        chk("midrst_y_data", {dif0.y_data, dif4.y_data}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("midrst_no_write", wcnt0 - b0, 0);
        chk("midrst_no_done", dcnt0 - d0c, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
